// File: rtl/ordenador_comparador_if.sv
// Host-side bus of the bubble-sort controller: word-bank write/read port,
// start/busy/done handshake and the swap count of the last sort.
interface ordenador_comparador_if #(
    parameter int N = 4
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N * (N - 1) / 2 + 1);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] n_trocas;

    modport master (
        output wr_en, wr_addr, wr_data, start, rd_addr,
        input  rd_data, busy, done, n_trocas
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_addr,
        output rd_data, busy, done, n_trocas
    );
endinterface

// File: rtl/ordenador_comparador.sv
// Ascending bubble sort with early exit over N 4-bit words, one compare per
// cycle through a single shared comparador4; swaps take an extra cycle.
module comparador4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       AmaiorB,
    output logic       AmenorB,
    output logic       AigualB
);
    assign AmaiorB = (A > B);
    assign AmenorB = (A < B);
    assign AigualB = (A == B);
endmodule

module ordenador_comparador #(
    parameter int N = 4
) (
    input logic                  clk,
    input logic                  rst,
    ordenador_comparador_if.slave bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N * (N - 1) / 2 + 1);

    typedef enum logic [1:0] {OCIOSO, COMPARA, TROCA, FIM} estado_t;

    estado_t           estado, proxEstado;
    logic [N-1:0][3:0] mem;
    logic [AW-1:0]     idx, idxProx, passo;
    logic              trocouPasso;
    logic [CW-1:0]     nTrocas;
    logic [3:0]        rdData;
    logic              aMaiorB, aMenorB, aIgualB;
    logic              unusedCmp;
    logic              fimPasso, ultimoPasso;
    logic              fazEscrita, aceitaStart, fazTroca, avanca, proxPasso;

    assign idxProx = idx + 1'b1;

    comparador4 uComparador (
        .A       (mem[idx]),
        .B       (mem[idxProx]),
        .AmaiorB (aMaiorB),
        .AmenorB (aMenorB),
        .AigualB (aIgualB)
    );

    // Only "greater" drives the decision, so equal words stay in place.
    assign unusedCmp = aMenorB ^ aIgualB;

    assign fimPasso    = (int'(idx) + int'(passo)) >= (N - 2);
    assign ultimoPasso = int'(passo) == (N - 2);

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= proxEstado;
    end

    always_comb begin
        proxEstado  = estado;
        fazEscrita  = 1'b0;
        aceitaStart = 1'b0;
        fazTroca    = 1'b0;
        avanca      = 1'b0;
        proxPasso   = 1'b0;
        case (estado)
            OCIOSO: begin
                fazEscrita = bus.wr_en && (int'(bus.wr_addr) < N);
                if (bus.start) begin
                    aceitaStart = 1'b1;
                    proxEstado  = COMPARA;
                end
            end
            COMPARA: begin
                if (aMaiorB) begin
                    proxEstado = TROCA;
                end else if (!fimPasso) begin
                    avanca = 1'b1;
                end else if (!trocouPasso || ultimoPasso) begin
                    proxEstado = FIM;
                end else begin
                    proxPasso = 1'b1;
                end
            end
            TROCA: begin
                fazTroca   = 1'b1;
                proxEstado = COMPARA;
                // The swap just made counts for this pass, so only the
                // final pass can finish from here.
                if (!fimPasso)        avanca     = 1'b1;
                else if (ultimoPasso) proxEstado = FIM;
                else                  proxPasso  = 1'b1;
            end
            FIM:     proxEstado = OCIOSO;
            default: proxEstado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem         <= '0;
            rdData      <= '0;
            nTrocas     <= '0;
            idx         <= '0;
            passo       <= '0;
            trocouPasso <= 1'b0;
        end else begin
            if (fazEscrita) mem[bus.wr_addr] <= bus.wr_data;
            if (fazTroca) begin
                mem[idx]     <= mem[idxProx];
                mem[idxProx] <= mem[idx];
                nTrocas      <= nTrocas + 1'b1;
                trocouPasso  <= 1'b1;
            end
            if (aceitaStart) begin
                nTrocas     <= '0;
                idx         <= '0;
                passo       <= '0;
                trocouPasso <= 1'b0;
            end
            if (avanca) idx <= idxProx;
            if (proxPasso) begin
                idx         <= '0;
                passo       <= passo + 1'b1;
                trocouPasso <= 1'b0;
            end
            rdData <= (int'(bus.rd_addr) < N) ? mem[bus.rd_addr] : 4'h0;
        end
    end

    assign bus.rd_data  = rdData;
    assign bus.busy     = (estado == COMPARA) || (estado == TROCA);
    assign bus.done     = (estado == FIM);
    assign bus.n_trocas = nTrocas;
endmodule
